priority_arbiter_rr: RTL and testbench
======================================

# priority_arbiter_rr

Parametrised, registered N-requester arbiter built around a generalised priority-encode core.
- Grants one requester at a time and holds the grant until that requester drops its request.
- Two modes, selectable at run time: fixed priority (highest index wins) and round-robin (rotating start point for fair sharing).
- Sits between multiple request sources and a single shared resource.
- Outputs are a one-hot grant, a binary index and a valid flag.

## Interface
Parameters:
- N, 8, number of requesters (≥2)
- W, $clog2(N), width of the grant index

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- mode  input  1  0 = fixed priority, 1 = round-robin; sampled only in IDLE
- req  input  N  request vector, bit i = requester i
- gnt  output  N  one-hot grant, registered
- gnt_idx  output  W  binary index of granted requester, registered
- gnt_valid  output  1  high while a grant is held, registered

## Operation
- FSM states: IDLE, GRANT.
- Search rule:
  - Fixed mode: highest set bit of req wins (MSB priority).
  - Round-robin mode: descending search starting at ptr, wrapping from 0 to N-1; first set bit wins.
- IDLE:
  - req == 0: stay in IDLE.
  - Otherwise: latch the winner into gnt, gnt_idx and gnt_valid=1, then go to GRANT.
- GRANT:
  - req[gnt_idx]==1: hold gnt, gnt_idx and gnt_valid unchanged. Other req bits and mode are ignored.
  - req[gnt_idx]==0: clear gnt and gnt_valid, then go to IDLE.
  - ptr update on release: ptr ← (gnt_idx==0) ? N-1 : gnt_idx-1 (the released requester becomes lowest priority). ptr updates in both modes but is only used in round-robin.
- gnt_idx keeps its last value in IDLE. Consumers qualify it with gnt_valid.
- Arithmetic: ptr is W bits. Wrap is explicit modulo N, so it is correct when N is not a power of two.
- Invariant: gnt is zero or one-hot, and gnt==(1<<gnt_idx) whenever gnt_valid=1.

## Timing
- Reset (rst=1 at a clk edge): gnt=0, gnt_idx=0, gnt_valid=0, ptr=N-1, state=IDLE. This applies in any state, including mid-grant. The grant is dropped with no release handshake.
- Grant latency: req sampled at edge k, gnt valid after edge k (1 cycle).
- Release latency: req[gnt_idx] low at edge k, gnt cleared after edge k.
- Bubble: there is always at least one IDLE cycle between two grants. The earliest re-grant is at edge k+1.
- Simultaneous events:
  - Release plus new requests at the same edge: the release wins and new requests are evaluated in IDLE on the next edge using the updated ptr.
  - rst together with any req: rst wins.
- Mode change while in GRANT takes effect at the next IDLE evaluation.

## Structure
- Shared package (arb_pkg): state encoding localparams (IDLE=1'b0, GRANT=1'b1) and the mode constants (MODE_FIXED=0, MODE_RR=1).
- Sub-module priority_encoder_n:
  - Combinational, parameters N and W.
  - Inputs: req[N-1:0] and start[W-1:0]. Outputs: idx[W-1:0] and found.
  - Performs a descending wrap-around search from start.
  - Fixed mode drives start=N-1.
  - This generalises the 8:3 priority encoder and is reused elsewhere.
- Top level: FSM, ptr register, output registers, one-hot decode of idx.

## Test plan
All scenarios use N=8.
1. Reset and idle: rst high 2 cycles, then req=0 for 5 cycles -> gnt=0, gnt_valid=0, gnt_idx=0 throughout.
2. Fixed priority: mode=0, req=8'b0010_1101 -> after one edge gnt=8'b0010_0000, gnt_idx=5. Hold 3 cycles with the other bits toggling -> grant unchanged.
3. Release and bubble: from scenario 2, req=8'b0000_1101 -> gnt=0 for one cycle, then gnt_idx=3.
4. Round-robin fairness: mode=1, req=8'b1111_1111 held, each granted requester drops its bit for one cycle after 2 cycles of grant -> grant order 7,6,5,4,3,2,1,0,7 (wrap checked).
5. Round-robin skip: mode=1, ptr=4 after releasing idx 5, req=8'b1000_0001 -> gnt_idx=0, then after release of 0, gnt_idx=7.
6. Reset mid-grant: grant held on idx 6, rst=1 for one edge -> gnt=0, gnt_valid=0. With mode=1 and req=8'b1111_1111 -> next grant is idx 7, confirming ptr reset to N-1.

Source files
------------

// File: rtl/priority_arbiter_rr_pkg.sv
// Shared constants for the priority / round-robin arbiter: FSM state
// encoding and the run-time arbitration mode values.
package arb_pkg;

    typedef logic state_t;

    localparam state_t IDLE  = 1'b0;
    localparam state_t GRANT = 1'b1;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage : arb_pkg

// File: rtl/priority_arbiter_rr_if.sv
// Request/grant bundle between the request sources (master) and the
// arbiter (slave). Grant outputs are registered inside the arbiter.
interface priority_arbiter_rr_if #(
    parameter int N = 8,
    parameter int W = $clog2(N)
);
    logic [N-1:0] req;
    logic         mode;
    logic [N-1:0] gnt;
    logic [W-1:0] gnt_idx;
    logic         gnt_valid;

    modport master (
        output req,
        output mode,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid
    );

    modport slave (
        input  req,
        input  mode,
        output gnt,
        output gnt_idx,
        output gnt_valid
    );
endinterface : priority_arbiter_rr_if

// File: rtl/priority_encoder_n.sv
// Generalised N-input priority encoder: descending search starting at
// `start`, wrapping from 0 back to N-1. start = N-1 gives plain MSB
// priority. The wrap is an explicit modulo-N so non power-of-two N works.
module priority_encoder_n #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    // First set bit met while walking down from start, with wrap.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path
        // leaves it unassigned, which would otherwise infer a latch.
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            logic [W-1:0] cand;
            cand = W'((int'(start) + N - i) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule : priority_encoder_n

// File: rtl/priority_arbiter_rr.sv
// Registered N-requester arbiter. A grant is held until its requester
// drops its request; every release forces one IDLE cycle before the
// next grant. Round-robin mode starts the search just below the most
// recently released requester.
module priority_arbiter_rr
    import arb_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    priority_arbiter_rr_if.slave    bus
);

    localparam logic [W-1:0] PTR_MAX = W'(N - 1);
    localparam logic [N-1:0] ONE_HOT_LSB = {{(N-1){1'b0}}, 1'b1};

    state_t       state, state_d;
    logic [W-1:0] ptr, ptr_d;
    logic [N-1:0] gnt_q, gnt_d;
    logic [W-1:0] idx_q, idx_d;
    logic         valid_q, valid_d;

    logic [W-1:0] start;
    logic [W-1:0] enc_idx;
    logic         enc_found;
    logic         release_now;

    // Fixed mode always searches from the top; round-robin from ptr.
    assign start       = (bus.mode == MODE_RR) ? ptr : PTR_MAX;
    assign release_now = !bus.req[idx_q];

    priority_encoder_n #(.N(N), .W(W)) u_enc (
        .req   (bus.req),
        .start (start),
        .idx   (enc_idx),
        .found (enc_found)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state: grant on any request, release when holder drops.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (enc_found)   state_d = GRANT;
            GRANT:   if (release_now) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values: latch winner in IDLE, clear and
    // rotate ptr on release, otherwise hold.
    always_comb begin
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        ptr_d   = ptr;
        case (state)
            IDLE: begin
                if (enc_found) begin
                    gnt_d   = ONE_HOT_LSB << enc_idx;
                    idx_d   = enc_idx;
                    valid_d = 1'b1;
                end
            end
            GRANT: begin
                if (release_now) begin
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = (idx_q == '0) ? PTR_MAX : idx_q - 1'b1;
                end
            end
            default: begin
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // Registered grant outputs and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr     <= PTR_MAX;
        end else begin
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ptr     <= ptr_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;

endmodule : priority_arbiter_rr

// File: tb/tb_priority_arbiter_rr.sv
// Self-checking bench for priority_arbiter_rr (N=8): a behavioural
// arbiter model checked on every falling edge, plus directed scenarios
// with hand-computed expectations.
module tb_priority_arbiter_rr;

    localparam int N = 8;
    localparam int W = $clog2(N);

    logic clk;
    logic rst;

    priority_arbiter_rr_if #(.N(N), .W(W)) bus ();

    priority_arbiter_rr #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: holder index (or -1 when idle) and rotating
    // pointer, advanced from the rules on each rising edge.
    int m_holder = -1;
    int m_idx    = 0;
    int m_ptr    = N - 1;

    always @(posedge clk) begin
        if (rst) begin
            m_holder = -1;
            m_idx    = 0;
            m_ptr    = N - 1;
        end else if (m_holder < 0) begin
            int top;
            top = bus.mode ? m_ptr : N - 1;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (top - k + N) % N;
                if (m_holder < 0 && bus.req[c]) m_holder = c;
            end
            if (m_holder >= 0) m_idx = m_holder;
        end else if (!bus.req[m_holder]) begin
            m_ptr    = (m_holder + N - 1) % N;
            m_holder = -1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en) begin
            logic [N-1:0] exp_gnt;
            exp_gnt = (m_holder >= 0) ? N'(1) << m_holder : '0;
            check("model_gnt", 32'(bus.gnt), 32'(exp_gnt));
            check("model_idx", 32'(bus.gnt_idx), 32'(m_idx));
            check("model_valid", 32'(bus.gnt_valid), 32'(m_holder >= 0));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string name, input int idx);
        check({name, "_valid"}, 32'(bus.gnt_valid), 32'd1);
        check({name, "_idx"}, 32'(bus.gnt_idx), 32'(idx));
        check({name, "_gnt"}, 32'(bus.gnt), 32'(1) << idx);
    endtask

    task automatic expect_idle(input string name);
        check({name, "_valid"}, 32'(bus.gnt_valid), 32'd0);
        check({name, "_gnt"}, 32'(bus.gnt), 32'd0);
    endtask

    initial begin
        logic [7:0] toggles [3];
        int rr_order [9];
        toggles  = '{8'b0010_0010, 8'b0011_1111, 8'b0010_0000};
        rr_order = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

        // 1. Reset and idle.
        rst = 1'b1; bus.req = '0; bus.mode = 1'b0;
        tick(1);
        check_en = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            expect_idle("s1_idle");
            check("s1_idx", 32'(bus.gnt_idx), 32'd0);
        end

        // 2. Fixed priority, MSB wins, grant held while others toggle.
        bus.mode = 1'b0; bus.req = 8'b0010_1101;
        tick(1);
        check("s2_gnt_lit", 32'(bus.gnt), 32'h20);
        expect_grant("s2_first", 5);
        for (int i = 0; i < 3; i++) begin
            bus.req = toggles[i];
            tick(1);
            expect_grant("s2_hold", 5);
        end

        // 3. Release, one bubble cycle, then next fixed winner.
        bus.req = 8'b0000_1101;
        tick(1);
        expect_idle("s3_bubble");
        tick(1);
        expect_grant("s3_regrant", 3);
        bus.req = '0;
        tick(1);
        expect_idle("s3_release");

        // 4. Round-robin fairness from a fresh pointer.
        rst = 1'b1;
        tick(1);
        rst = 1'b0; bus.mode = 1'b1; bus.req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick(1);
            expect_grant("s4_order", rr_order[i]);
            tick(1);
            expect_grant("s4_hold", rr_order[i]);
            if (i < 8) begin
                bus.req = 8'hFF & ~(8'(1) << rr_order[i]);
                tick(1);
                expect_idle("s4_bubble");
                bus.req = 8'hFF;
            end
        end

        // 5. Round-robin skip: release 7, grant 5, release 5 (ptr=4).
        bus.req = 8'b0010_0000;
        tick(1);
        expect_idle("s5_rel7");
        tick(1);
        expect_grant("s5_g5", 5);
        bus.req = 8'b1000_0001;
        tick(1);
        expect_idle("s5_rel5");
        tick(1);
        expect_grant("s5_g0", 0);
        bus.req = 8'b1000_0000;
        tick(1);
        expect_idle("s5_rel0");
        tick(1);
        expect_grant("s5_g7", 7);

        // Mode change during a grant: grant held, no effect until IDLE.
        bus.req = 8'b1000_0001; bus.mode = 1'b0;
        tick(1);
        expect_grant("mode_hold", 7);
        bus.mode = 1'b1;

        // 6. Reset mid-grant on idx 6, then ptr must be back at N-1.
        bus.req = 8'b0100_0000;
        tick(1);
        expect_idle("s6_rel7");
        tick(1);
        expect_grant("s6_g6", 6);
        tick(1);
        expect_grant("s6_hold", 6);
        rst = 1'b1; bus.req = 8'hFF; bus.mode = 1'b1;
        tick(1);
        expect_idle("s6_rst");
        check("s6_rst_idx", 32'(bus.gnt_idx), 32'd0);
        rst = 1'b0;
        tick(1);
        expect_grant("s6_after_rst", 7);

        bus.req = '0;
        tick(2);
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_priority_arbiter_rr
